// File: rtl/cgra_col_activity_ctrl_pkg.sv
// Shared constants and width helpers for the column activity controller.
package cgra_col_activity_ctrl_pkg;

   localparam int CGRA_N_COL           = 4;
   localparam int CGRA_ACT_CNT_WIDTH   = 32;
   localparam int CGRA_CLK_HOLD_CYCLES = 2;
   localparam int CGRA_ACT_SEL_GLOBAL  = CGRA_N_COL;

   // A zero hold still needs a 1-bit register so the counter stays legal.
   function automatic int hold_width(input int hold_cycles);
      return (hold_cycles > 0) ? $clog2(hold_cycles + 1) : 1;
   endfunction

   function automatic int sel_width(input int n_col);
      return $clog2(n_col + 1);
   endfunction

endpackage

// File: rtl/cgra_col_activity_ctrl_if.sv
// Control/readback bundle between cgra_controller side and the activity controller.
interface cgra_col_activity_ctrl_if
   import cgra_col_activity_ctrl_pkg::*;
#(
   parameter int N_COL     = CGRA_N_COL,
   parameter int CNT_WIDTH = CGRA_ACT_CNT_WIDTH
);
   localparam int SEL_W = sel_width(N_COL);

   logic [N_COL-1:0]     col_e_i;
   logic                 force_on_i;
   logic                 cnt_en_i;
   logic                 cnt_clr_i;
   logic                 snap_i;
   logic [SEL_W-1:0]     rd_sel_i;
   logic [CNT_WIDTH-1:0] rd_data_o;
   logic [N_COL-1:0]     col_clk_en_o;
   logic                 col_busy_o;

   modport master (
      output col_e_i, force_on_i, cnt_en_i, cnt_clr_i, snap_i, rd_sel_i,
      input  rd_data_o, col_clk_en_o, col_busy_o
   );

   modport slave (
      input  col_e_i, force_on_i, cnt_en_i, cnt_clr_i, snap_i, rd_sel_i,
      output rd_data_o, col_clk_en_o, col_busy_o
   );

endinterface

// File: rtl/cgra_col_act_unit.sv
// One column: enable hold counter, clock-enable logic, saturating active counter and shadow.
module cgra_col_act_unit
   import cgra_col_activity_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH   = CGRA_ACT_CNT_WIDTH,
   parameter int HOLD_CYCLES = CGRA_CLK_HOLD_CYCLES
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 col_e,
   input  logic                 force_on,
   input  logic                 cnt_en,
   input  logic                 cnt_clr,
   input  logic                 snap,
   output logic                 col_clk_en,
   output logic [CNT_WIDTH-1:0] shadow
);
   localparam int HOLD_W = hold_width(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

   logic [HOLD_W-1:0]    hold_reg, hold_next;
   logic [CNT_WIDTH-1:0] act_reg, act_next;
   logic [CNT_WIDTH-1:0] shadow_reg;

   always_comb begin
      hold_next = hold_reg;
      if (col_e) begin
         hold_next = HOLD_LOAD;
      end else if (hold_reg != '0) begin
         hold_next = hold_reg - HOLD_W'(1);
      end
   end

   // hold_reg is forced to zero by reset, so the enable follows the inputs alone then.
   assign col_clk_en = col_e | force_on | (hold_reg != '0);

   always_comb begin
      act_next = act_reg;
      if (cnt_clr) begin
         act_next = '0;
      end else if (cnt_en && col_clk_en && (act_reg != '1)) begin
         act_next = act_reg + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_reg   <= '0;
         act_reg    <= '0;
         shadow_reg <= '0;
      end else begin
         hold_reg <= hold_next;
         act_reg  <= act_next;
         if (snap) begin
            shadow_reg <= act_reg;
         end
      end
   end

   assign shadow = shadow_reg;

endmodule

// File: rtl/cgra_col_activity_ctrl.sv
// Per-column clock-enable hold and activity profiling with a global cycle counter and shadow readback.
module cgra_col_activity_ctrl
   import cgra_col_activity_ctrl_pkg::*;
#(
   parameter int N_COL       = CGRA_N_COL,
   parameter int CNT_WIDTH   = CGRA_ACT_CNT_WIDTH,
   parameter int HOLD_CYCLES = CGRA_CLK_HOLD_CYCLES
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   cgra_col_activity_ctrl_if.slave bus
);
   localparam int SEL_W = sel_width(N_COL);

   logic [N_COL:0][CNT_WIDTH-1:0] shadow_all;
   logic [N_COL-1:0]              col_clk_en;
   logic [CNT_WIDTH-1:0]          gcc_reg, gcc_next, gcc_shadow_reg;
   logic [CNT_WIDTH-1:0]          rd_data;

   genvar gi;
   generate
      for (gi = 0; gi < N_COL; gi++) begin : g_col
         cgra_col_act_unit #(
            .CNT_WIDTH   (CNT_WIDTH),
            .HOLD_CYCLES (HOLD_CYCLES)
         ) u_unit (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .col_e      (bus.col_e_i[gi]),
            .force_on   (bus.force_on_i),
            .cnt_en     (bus.cnt_en_i),
            .cnt_clr    (bus.cnt_clr_i),
            .snap       (bus.snap_i),
            .col_clk_en (col_clk_en[gi]),
            .shadow     (shadow_all[gi])
         );
      end
   endgenerate

   always_comb begin
      gcc_next = gcc_reg;
      if (bus.cnt_clr_i) begin
         gcc_next = '0;
      end else if (bus.cnt_en_i && (gcc_reg != '1)) begin
         gcc_next = gcc_reg + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gcc_reg        <= '0;
         gcc_shadow_reg <= '0;
      end else begin
         gcc_reg <= gcc_next;
         if (bus.snap_i) begin
            gcc_shadow_reg <= gcc_reg;
         end
      end
   end

   assign shadow_all[N_COL] = gcc_shadow_reg;

   // Selects above the global index fall through to zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i <= N_COL; i++) begin
         if (bus.rd_sel_i == SEL_W'(i)) begin
            rd_data = shadow_all[i];
         end
      end
   end

   assign bus.rd_data_o    = rd_data;
   assign bus.col_clk_en_o = col_clk_en;
   assign bus.col_busy_o   = |col_clk_en;

endmodule

// File: tb/tb_cgra_col_activity_ctrl.sv
// Scoreboard bench: three controllers (hold 2, hold 0, 4-bit counters) driven by shared stimulus.
module tb_cgra_col_activity_ctrl;
   import cgra_col_activity_ctrl_pkg::*;

   localparam int NC = 4;
   localparam int SW = $clog2(NC + 1);

   typedef struct {
      string       tag;
      int          src;
      logic [31:0] exp;
   } sb_item_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NC-1:0] col_e;
   logic          force_on, cnt_en, cnt_clr, snap;
   logic [SW-1:0] rd_sel;

   sb_item_t sb_q[$];
   int       n_checks = 0;
   int       n_pass   = 0;

   always #5 clk = ~clk;

   cgra_col_activity_ctrl_if #(.N_COL(NC), .CNT_WIDTH(32)) bus_a ();
   cgra_col_activity_ctrl_if #(.N_COL(NC), .CNT_WIDTH(32)) bus_z ();
   cgra_col_activity_ctrl_if #(.N_COL(NC), .CNT_WIDTH(4))  bus_s ();

   assign bus_a.col_e_i = col_e;   assign bus_z.col_e_i = col_e;   assign bus_s.col_e_i = col_e;
   assign bus_a.force_on_i = force_on; assign bus_z.force_on_i = force_on; assign bus_s.force_on_i = force_on;
   assign bus_a.cnt_en_i = cnt_en; assign bus_z.cnt_en_i = cnt_en; assign bus_s.cnt_en_i = cnt_en;
   assign bus_a.cnt_clr_i = cnt_clr; assign bus_z.cnt_clr_i = cnt_clr; assign bus_s.cnt_clr_i = cnt_clr;
   assign bus_a.snap_i = snap;     assign bus_z.snap_i = snap;     assign bus_s.snap_i = snap;
   assign bus_a.rd_sel_i = rd_sel; assign bus_z.rd_sel_i = rd_sel; assign bus_s.rd_sel_i = rd_sel;

   cgra_col_activity_ctrl #(.N_COL(NC), .CNT_WIDTH(32), .HOLD_CYCLES(2)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_a.slave));
   cgra_col_activity_ctrl #(.N_COL(NC), .CNT_WIDTH(32), .HOLD_CYCLES(0)) dut_z (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_z.slave));
   cgra_col_activity_ctrl #(.N_COL(NC), .CNT_WIDTH(4), .HOLD_CYCLES(2)) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_s.slave));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s got=%0h", tag, got);
      end else begin
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // src: 0/1/2 = enables of a/z/s, 3/4/5 = rd_data of a/z/s, 6 = busy of a
   function automatic logic [31:0] observe(input int src);
      case (src)
         0: return 32'(bus_a.col_clk_en_o);
         1: return 32'(bus_z.col_clk_en_o);
         2: return 32'(bus_s.col_clk_en_o);
         3: return bus_a.rd_data_o;
         4: return bus_z.rd_data_o;
         5: return 32'(bus_s.rd_data_o);
         6: return 32'(bus_a.col_busy_o);
         default: return 'x;
      endcase
   endfunction

   task automatic expect_val(input string tag, input int src, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.src = src;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic drive(input int ce, input int f, input int en, input int clr, input int sn, input int sel);
      col_e    = NC'(ce);
      force_on = f[0];
      cnt_en   = en[0];
      cnt_clr  = clr[0];
      snap     = sn[0];
      rd_sel   = SW'(sel);
   endtask

   // Compare this cycle's expectations mid-cycle, then advance past the next edge.
   task automatic tick();
      sb_item_t it;
      @(negedge clk);
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         check_eq(it.tag, observe(it.src), it.exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] re_pat, re_exp_a;
      re_pat   = 6'b000101;
      re_exp_a = 6'b011111;

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      expect_val("rst_en", 0, 0);
      expect_val("rst_rd", 3, 0);
      expect_val("rst_busy", 6, 0);
      tick();
      drive(5, 0, 0, 0, 0, 0);
      expect_val("rst_en_pass", 0, 5);
      tick();
      drive(0, 1, 0, 0, 0, 0);
      expect_val("rst_force", 1, 15);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();

      for (int c = 0; c < 7; c++) begin
         drive((c < 3) ? 2 : 0, 0, 0, 0, 0, 0);
         expect_val($sformatf("hold2_c%0d", c), 0, (c < 5) ? 2 : 0);
         expect_val($sformatf("hold0_c%0d", c), 1, (c < 3) ? 2 : 0);
         expect_val($sformatf("busy_c%0d", c), 6, (c < 5) ? 1 : 0);
         tick();
      end

      for (int c = 0; c < 6; c++) begin
         drive(int'(re_pat[c]), 0, 0, 0, 0, 0);
         expect_val($sformatf("retrig_a_c%0d", c), 0, 32'(re_exp_a[c]));
         expect_val($sformatf("retrig_z_c%0d", c), 1, 32'(re_pat[c]));
         tick();
      end

      drive(0, 1, 0, 0, 0, 0);
      expect_val("force_a", 0, 15);
      expect_val("force_z", 1, 15);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      expect_val("force_off", 0, 0);
      tick();

      drive(0, 0, 0, 1, 0, 0);
      tick();
      for (int c = 0; c < 102; c++) begin
         drive((c < 10) ? 4 : 0, 0, 1, 0, (c == 101) ? 1 : 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 2);
      expect_val("prof_col2_a", 3, 12);
      expect_val("prof_col2_z", 4, 10);
      expect_val("prof_col2_s", 5, 12);
      tick();
      drive(0, 0, 0, 0, 0, CGRA_ACT_SEL_GLOBAL);
      expect_val("prof_gcc_a", 3, 101);
      expect_val("prof_gcc_z", 4, 101);
      expect_val("prof_gcc_sat", 5, 15);
      tick();
      drive(0, 0, 0, 0, 0, 5);
      expect_val("sel5_zero", 3, 0);
      tick();
      drive(0, 0, 0, 0, 0, 7);
      expect_val("sel7_zero", 3, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      expect_val("prof_col0", 3, 0);
      tick();

      drive(0, 0, 0, 1, 1, 4);
      expect_val("snapclr_old", 3, 101);
      tick();
      drive(0, 0, 0, 0, 0, 4);
      expect_val("snapclr_gcc_a", 3, 102);
      expect_val("snapclr_gcc_s", 5, 15);
      tick();
      drive(0, 0, 0, 0, 0, 2);
      expect_val("snapclr_col2_s", 5, 12);
      tick();
      drive(0, 0, 0, 0, 1, 4);
      expect_val("shadow_kept", 3, 102);
      tick();
      drive(0, 0, 0, 0, 0, 4);
      expect_val("live_cleared_a", 3, 0);
      expect_val("live_cleared_s", 5, 0);
      tick();
      drive(0, 0, 1, 1, 0, 4);
      tick();
      drive(0, 0, 0, 0, 1, 4);
      tick();
      drive(0, 0, 0, 0, 0, 4);
      expect_val("clr_over_inc", 3, 0);
      tick();

      drive(0, 0, 1, 0, 0, 4);
      tick();
      drive(8, 0, 1, 0, 1, 4);
      expect_val("mh_en_c0", 0, 8);
      tick();
      drive(0, 0, 0, 0, 0, 4);
      expect_val("mh_en_c1", 0, 8);
      expect_val("mh_shadow", 3, 1);
      tick();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 4);
      expect_val("mh_rst_en", 0, 0);
      expect_val("mh_rst_busy", 6, 0);
      expect_val("mh_rst_rd", 3, 0);
      tick();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 3);
      expect_val("post_rst_en", 0, 0);
      expect_val("post_rst_col3", 3, 0);
      tick();
      drive(0, 0, 0, 0, 1, 4);
      expect_val("post_rst_gcc", 3, 0);
      tick();
      drive(0, 0, 0, 0, 0, 4);
      expect_val("post_rst_snap_a", 3, 0);
      expect_val("post_rst_snap_s", 5, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
